reservation_station: RTL
========================

Name: reservation_station

Overview:
- Arithmetic/branch reservation station directly downstream of the issue stage.
- Buffers up to DEPTH issued non-memory instructions together with their operand status/data pairs.
- Snoops the ALU and LSB common data buses (CDB) to wake up waiting operands.
- Dispatches one ready instruction per cycle to the ALU, oldest-index-first by slot order (lowest ready index).

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- OP_W, 6, opcode width, equal to the issue-stage opcode width.
- ROB_W, 5, ROB tag width.
- READY_TAG, 32'hFFFF_FFFF, status value meaning "operand data valid"; any other status value is a zero-extended ROB tag.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global ready; low = stall.
- clear  in  1  mispredict flush, synchronous.
- rs_en_in  in  1  insert request from issue.
- rob_in  in  ROB_W  destination ROB tag of the inserted instruction.
- op_in  in  OP_W  opcode.
- q1_in  in  32  operand-1 status.
- v1_in  in  32  operand-1 data.
- q2_in  in  32  operand-2 status.
- v2_in  in  32  operand-2 data.
- rs_full  out  1  combinational; high when all DEPTH entries are busy.
- alu_cdb_en  in  1  ALU result broadcast valid.
- alu_cdb_rob  in  ROB_W  ALU result tag.
- alu_cdb_val  in  32  ALU result value.
- lsb_cdb_en  in  1  LSB result broadcast valid.
- lsb_cdb_rob  in  ROB_W  LSB result tag.
- lsb_cdb_val  in  32  LSB result value.
- alu_en  out  1  registered; dispatch valid for exactly one cycle.
- alu_op  out  OP_W  dispatched opcode.
- alu_a  out  32  operand-1 value.
- alu_b  out  32  operand-2 value.
- alu_rob  out  ROB_W  dispatched ROB tag.

Behaviour:
- Reset (rst_in=1 at edge): all busy bits 0; alu_en, alu_op, alu_a, alu_b, alu_rob = 0. Reset takes priority over everything.
- Entry fields: busy, op, rob, q1, v1, q2, v2. An entry is ready when busy && q1==READY_TAG && q2==READY_TAG.
- Edge priority: rst_in, then clear, then rdy_in.
- rdy_in=0 (no reset, no clear): all entry state holds; alu_en registers 0; other alu_* outputs hold.
- clear=1: all busy bits go to 0; alu_en registers 0. An insertion and any wakeups in that cycle are discarded.
- Insertion (rs_en_in && !rs_full): writes the lowest-index free entry at the edge.
  - Incoming operand snoop: for each operand, if qX_in != READY_TAG and a CDB port is valid with {zero-extended tag}==qX_in, store that CDB value with qX=READY_TAG.
  - If both CDB ports match, the ALU port wins.
  - rs_en_in with rs_full=1 is a protocol violation and is ignored; no entry changes.
- Wakeup: on every rdy edge, each busy entry operand whose q equals a valid CDB tag captures the value and sets q=READY_TAG. ALU port has priority over the LSB port on a tag match.
- Dispatch:
  - Select is combinational over the pre-edge state: the lowest-index ready entry.
  - At the edge: alu_en<=1, alu_* <= entry fields, and the entry's busy is cleared.
  - If no entry is ready, alu_en<=0.
  - No same-cycle CDB bypass into dispatch. An operand woken at edge E makes its entry eligible for dispatch at edge E+1.
- Latency: an entry inserted fully ready at edge E drives alu_en=1 after edge E+1. Minimum issue-to-ALU latency is 1 cycle.
- Simultaneous events:
  - Insertion and dispatch in the same cycle are allowed.
  - The freed slot is not reusable until the next cycle; rs_full is computed from pre-edge busy bits.
- rs_full = &busy (pre-edge).
  - Issue must not assert rs_en_in while rs_full=1.
  - A slot freed by dispatch deasserts rs_full in the following cycle.
- Throughput: at most 1 insert and 1 dispatch per cycle.
- The all-ones READY_TAG can never equal a valid ROB tag.

Test Plan:
- Reset, then insert op=add, rob=3, q1=q2=READY_TAG, v1=5, v2=7 at edge E -> after E+1: alu_en=1, alu_a=5, alu_b=7, alu_rob=3; after E+2: alu_en=0, rs_full=0.
- Insert rob=4 with q1=2, v1=X, q2=READY_TAG, v2=9; ALU CDB rob=2, val=0x11 two cycles later at edge W -> alu_en=1 after W+1 with alu_a=0x11, alu_b=9, alu_rob=4; no dispatch before that.
- Insert with q1=6 in the same cycle as LSB CDB rob=6, val=0xAB -> entry stored ready; dispatched after the next edge with alu_a=0xAB.
- Fill 8 entries all waiting on tag 1 -> rs_full=1; a 9th rs_en_in is ignored. ALU CDB rob=1, val=2 -> entries 0..7 dispatch on 8 consecutive cycles in index order; rs_full=0 the cycle after the first dispatch.
- Entries waiting, pulse clear together with rs_en_in -> all busy=0, rs_full=0, no alu_en ever asserts; the CDB for their tags then has no effect.
- Ready entry present, rdy_in=0 for 3 cycles -> alu_en=0 and state held; rdy_in=1 -> dispatch after the next edge. rst_in mid-run -> all outputs 0 after the edge.

Source files
------------

// File: rtl/rs_if.sv
// Issue, CDB snoop and ALU dispatch signals of the reservation station.
interface rs_if #(
  parameter int OP_W  = 6,
  parameter int ROB_W = 5
);
  logic             rdy_in;
  logic             clear;
  logic             rs_en_in;
  logic [ROB_W-1:0] rob_in;
  logic [OP_W-1:0]  op_in;
  logic [31:0]      q1_in;
  logic [31:0]      v1_in;
  logic [31:0]      q2_in;
  logic [31:0]      v2_in;
  logic             rs_full;
  logic             alu_cdb_en;
  logic [ROB_W-1:0] alu_cdb_rob;
  logic [31:0]      alu_cdb_val;
  logic             lsb_cdb_en;
  logic [ROB_W-1:0] lsb_cdb_rob;
  logic [31:0]      lsb_cdb_val;
  logic             alu_en;
  logic [OP_W-1:0]  alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [ROB_W-1:0] alu_rob;

  modport master (
    output rdy_in, clear, rs_en_in, rob_in, op_in, q1_in, v1_in, q2_in, v2_in,
    output alu_cdb_en, alu_cdb_rob, alu_cdb_val, lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val,
    input  rs_full, alu_en, alu_op, alu_a, alu_b, alu_rob
  );

  modport slave (
    input  rdy_in, clear, rs_en_in, rob_in, op_in, q1_in, v1_in, q2_in, v2_in,
    input  alu_cdb_en, alu_cdb_rob, alu_cdb_val, lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val,
    output rs_full, alu_en, alu_op, alu_a, alu_b, alu_rob
  );
endinterface

// File: rtl/reservation_station.sv
// ALU/branch reservation station: buffers issued instructions, wakes operands
// from the ALU/LSB CDBs and dispatches the lowest-index ready entry each cycle.
module reservation_station #(
  parameter int          DEPTH     = 8,
  parameter int          OP_W      = 6,
  parameter int          ROB_W     = 5,
  parameter logic [31:0] READY_TAG = 32'hFFFF_FFFF
) (
  input  logic clk_in,
  input  logic rst_in,
  rs_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_busy;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [ROB_W-1:0] r_rob [DEPTH];
  logic [31:0]      r_q1  [DEPTH];
  logic [31:0]      r_v1  [DEPTH];
  logic [31:0]      r_q2  [DEPTH];
  logic [31:0]      r_v2  [DEPTH];

  logic             r_alu_en;
  logic [OP_W-1:0]  r_alu_op;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [ROB_W-1:0] r_alu_rob;

  logic [DEPTH-1:0] w_busy_nxt;
  logic [OP_W-1:0]  w_op_nxt  [DEPTH];
  logic [ROB_W-1:0] w_rob_nxt [DEPTH];
  logic [31:0]      w_q1_nxt  [DEPTH];
  logic [31:0]      w_v1_nxt  [DEPTH];
  logic [31:0]      w_q2_nxt  [DEPTH];
  logic [31:0]      w_v2_nxt  [DEPTH];

  logic [DEPTH-1:0] w_ready;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_disp_idx;
  logic             w_disp_vld;
  logic             w_full;
  logic [31:0]      w_alu_tag;
  logic [31:0]      w_lsb_tag;

  assign w_alu_tag = {{(32-ROB_W){1'b0}}, bus.alu_cdb_rob};
  assign w_lsb_tag = {{(32-ROB_W){1'b0}}, bus.lsb_cdb_rob};
  assign w_full    = &r_busy;

  // Returns {status, data} after snooping both CDBs; ALU port wins on a double hit.
  function automatic logic [63:0] f_snoop(input logic [31:0] q, input logic [31:0] v);
    logic [63:0] res;
    res = {q, v};
    if (q != READY_TAG) begin
      if (bus.alu_cdb_en && q == w_alu_tag)
        res = {READY_TAG, bus.alu_cdb_val};
      else if (bus.lsb_cdb_en && q == w_lsb_tag)
        res = {READY_TAG, bus.lsb_cdb_val};
    end
    return res;
  endfunction

  always_comb begin
    w_ready    = '0;
    w_free_idx = '0;
    w_disp_idx = '0;
    w_disp_vld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && (r_q1[i] == READY_TAG) && (r_q2[i] == READY_TAG);
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
      if (w_ready[i]) begin
        w_disp_idx = IDX_W'(i);
        w_disp_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    w_op_nxt   = r_op;
    w_rob_nxt  = r_rob;
    w_q1_nxt   = r_q1;
    w_v1_nxt   = r_v1;
    w_q2_nxt   = r_q2;
    w_v2_nxt   = r_v2;
    if (bus.clear) begin
      w_busy_nxt = '0;
    end else if (bus.rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          {w_q1_nxt[i], w_v1_nxt[i]} = f_snoop(r_q1[i], r_v1[i]);
          {w_q2_nxt[i], w_v2_nxt[i]} = f_snoop(r_q2[i], r_v2[i]);
        end
      end
      if (w_disp_vld) w_busy_nxt[w_disp_idx] = 1'b0;
      // Free slot is chosen from pre-edge busy bits, so it never collides with dispatch.
      if (bus.rs_en_in && !w_full) begin
        w_busy_nxt[w_free_idx] = 1'b1;
        w_op_nxt[w_free_idx]   = bus.op_in;
        w_rob_nxt[w_free_idx]  = bus.rob_in;
        {w_q1_nxt[w_free_idx], w_v1_nxt[w_free_idx]} = f_snoop(bus.q1_in, bus.v1_in);
        {w_q2_nxt[w_free_idx], w_v2_nxt[w_free_idx]} = f_snoop(bus.q2_in, bus.v2_in);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy    <= '0;
      r_alu_en  <= 1'b0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_rob <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_op   <= w_op_nxt;
      r_rob  <= w_rob_nxt;
      r_q1   <= w_q1_nxt;
      r_v1   <= w_v1_nxt;
      r_q2   <= w_q2_nxt;
      r_v2   <= w_v2_nxt;
      if (bus.clear || !bus.rdy_in) begin
        r_alu_en <= 1'b0;
      end else begin
        r_alu_en <= w_disp_vld;
        if (w_disp_vld) begin
          r_alu_op  <= r_op[w_disp_idx];
          r_alu_a   <= r_v1[w_disp_idx];
          r_alu_b   <= r_v2[w_disp_idx];
          r_alu_rob <= r_rob[w_disp_idx];
        end
      end
    end
  end

  assign bus.rs_full = w_full;
  assign bus.alu_en  = r_alu_en;
  assign bus.alu_op  = r_alu_op;
  assign bus.alu_a   = r_alu_a;
  assign bus.alu_b   = r_alu_b;
  assign bus.alu_rob = r_alu_rob;
endmodule
